// File: rtl/avalon_mm_block_reader.sv
// Avalon-MM block read master with credit-limited pipelined reads.
// Returned words are buffered in a small FIFO and streamed out.
module avalon_mm_block_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W-1:0]  STEP  = ADDR_W'(DATA_W / 8);
    localparam logic [FIFO_AW+1:0] DEPTH = (FIFO_AW + 2)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   ONE_F = 1;
    localparam logic [CNT_W-1:0]   ONE_C = 1;

    state_t state, state_nx;

    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   total;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   returned;
    logic [CNT_W-1:0]   popped;
    logic [FIFO_AW:0]   outstanding;
    logic [FIFO_AW:0]   fifo_count;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_AW+1:0] in_flight;

    logic credit;
    logic accept;
    logic push;
    logic pop;
    logic launch;

    // Outstanding reads plus buffered words may never exceed the FIFO.
    assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit    = (in_flight < DEPTH) && (issued < total);
    assign accept    = avm_read && !avm_waitrequest;
    assign push      = avm_readdatavalid && (outstanding != '0);
    assign pop       = st_valid && st_ready;
    assign launch    = (state == IDLE) && start && (word_count != '0);

    assign avm_address    = addr;
    assign avm_byteenable = '1;
    assign st_valid       = (fifo_count != '0);
    assign st_data        = st_valid ? mem[rd_ptr] : '0;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        avm_read = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (word_count == '0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                busy     = 1'b1;
                avm_read = credit;
                if (accept && (issued + ONE_C == total))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (returned == total && popped == total)
                    state_nx = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Address, block counters and in-flight read tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr        <= '0;
            total       <= '0;
            issued      <= '0;
            returned    <= '0;
            popped      <= '0;
            outstanding <= '0;
        end else begin
            if (launch) begin
                addr     <= base_addr;
                total    <= word_count;
                issued   <= '0;
                returned <= '0;
                popped   <= '0;
            end else begin
                if (accept) begin
                    addr   <= addr + STEP;
                    issued <= issued + ONE_C;
                end
                if (push) returned <= returned + ONE_C;
                if (pop)  popped   <= popped + ONE_C;
            end
            unique case ({accept, push})
                2'b10:   outstanding <= outstanding + ONE_F;
                2'b01:   outstanding <= outstanding - ONE_F;
                default: ;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE_F;
                2'b01:   fifo_count <= fifo_count - ONE_F;
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avm_readdata;
    end

endmodule
